// File: rtl/wb_data_master.sv
// wb_data_master: single-beat Wishbone pipelined initiator for core loads/stores
module wb_data_master #(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic        o_cyc,
  output logic        o_stb,
  output logic [31:0] o_addr,
  output logic        o_we,
  output logic [31:0] o_data,
  output logic [3:0]  o_sel,
  input  logic        i_ack,
  input  logic        i_err,
  input  logic [31:0] i_data,
  input  logic        i_stall
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic             w_illegal;
  logic             w_resp;
  logic             w_tmo;
  logic [3:0]       w_sel;
  logic [31:0]      w_wdata;
  logic [31:0]      w_ext;
  // request decode (alignment, size code, masked store data) and load extension
  always_comb begin
    w_illegal = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) || (i_size == 2'b10 && i_addr[1:0] != 2'b00);
    w_sel     = i_size == 2'b00 ? 4'b0001 : i_size == 2'b01 ? 4'b0011 : 4'b1111;
    w_wdata   = !i_we ? 32'h0 : i_size == 2'b00 ? {24'h0, i_wdata[7:0]} : i_size == 2'b01 ? {16'h0, i_wdata[15:0]} : i_wdata;
    w_ext     = r_size == 2'b00 ? {{24{~r_unsigned & i_data[7]}}, i_data[7:0]}
              : r_size == 2'b01 ? {{16{~r_unsigned & i_data[15]}}, i_data[15:0]} : i_data;
    w_resp    = i_ack | i_err;
    w_tmo     = r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  end
  // transaction FSM; a response is honoured only once the strobe is accepted, and beats the timeout
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_rdata      <= 32'h0;
      o_fault      <= 1'b0;
      o_fault_code <= 2'b00;
      o_cyc        <= 1'b0;
      o_stb        <= 1'b0;
      o_addr       <= 32'h0;
      o_we         <= 1'b0;
      o_data       <= 32'h0;
      o_sel        <= 4'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req) begin
            o_busy <= 1'b1;
            if (w_illegal) begin
              r_state      <= DONE;
              o_done       <= 1'b1;
              o_fault      <= 1'b1;
              o_fault_code <= 2'b01;
            end else begin
              r_state    <= REQ;
              r_cnt      <= '0;
              r_size     <= i_size;
              r_unsigned <= i_unsigned;
              o_cyc      <= 1'b1;
              o_stb      <= 1'b1;
              o_addr     <= i_addr;
              o_we       <= i_we;
              o_data     <= w_wdata;
              o_sel      <= w_sel;
            end
          end
        end
        REQ, WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_resp && (r_state == WAIT || !i_stall)) begin
            r_state <= DONE;
            o_cyc   <= 1'b0;
            o_stb   <= 1'b0;
            o_done  <= 1'b1;
            if (i_err) begin
              o_fault      <= 1'b1;
              o_fault_code <= 2'b10;
            end else begin
              o_rdata <= o_we ? 32'h0 : w_ext;
            end
          end else if (w_tmo) begin
            r_state      <= DONE;
            o_cyc        <= 1'b0;
            o_stb        <= 1'b0;
            o_done       <= 1'b1;
            o_fault      <= 1'b1;
            o_fault_code <= 2'b11;
          end else if (r_state == REQ && !i_stall) begin
            r_state <= WAIT;
            o_stb   <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          o_busy       <= 1'b0;
          o_done       <= 1'b0;
          o_rdata      <= 32'h0;
          o_fault      <= 1'b0;
          o_fault_code <= 2'b00;
        end
      endcase
    end
  end
endmodule
